lte_up_dfe_trans_inf_antdeswitch: RTL and testbench
===================================================

Name: lte_up_dfe_trans_inf_antdeswitch

Overview:
Uplink counterpart of the downlink antenna-switch serializer. It takes the time-multiplexed 16-bit I/Q word stream of the 491.52 MHz antenna-switched interface, with its frame head and antenna-boundary marker. It rebuilds 32-bit {I,Q} samples, each tagged with its logical slot and physical antenna index. It sits between the uplink transceiver interface and the per-antenna uplink DFE chain, and checks that the antenna-boundary markers stay aligned.

Parameters:
ERR_CNT_W, 8, width of the saturating misalignment counter

Ports:
sys_clk_491p52  in  1  interface clock, 491.52 MHz
sys_rst_491p52  in  1  asynchronous reset, active-high
i_mod_sel  in  2  bandwidth: 0->5M, 1->10M, 2->15M, 3->20M
i_ant_pos  in  32  slot-to-antenna map; slot s uses bits [4s+2:4s]
i_fram  in  1  frame head; high on word 0 (I of slot 0) of a frame
i_xant  in  1  antenna-boundary marker; high on the last word of each antenna dwell
i_data  in  16  serial word stream; even word index = I, odd = Q
i_clr_err  in  1  clears o_err and o_err_cnt
o_fram  out  1  high with the first valid sample of each frame
o_vld  out  1  output sample valid
o_slot  out  3  logical slot of o_data
o_ant  out  3  physical antenna index of o_data
o_data  out  32  {I[31:16], Q[15:0]}
o_err  out  1  sticky flag: marker misalignment seen
o_err_cnt  out  ERR_CNT_W  saturating misalignment count

Behaviour:
- Reset: all outputs 0; block unsynced; counters 0; held I cleared.
- Unsynced: o_vld, o_fram stay 0 until the first i_fram. Error checks disabled.
- Latching at i_fram: i_mod_sel and i_ant_pos are latched. Mid-frame changes on either input have no effect until the next i_fram.
- Dwell length L in words:
  - 64 for mod_sel 0
  - 32 for mod_sel 1 and 2
  - 16 for mod_sel 3
- Word counter wcnt (6 bit):
  - Set to 0 on the i_fram word, otherwise incremented.
  - At wcnt == L-1 the next word gets wcnt 0 and slot increments mod 8 (slot 7 -> 0).
  - Slot is 0 on the i_fram word.
- Pairing:
  - Even wcnt: I is captured into a hold register.
  - Odd wcnt: o_data = {held I, i_data} is registered with o_vld = 1 on the next cycle.
  - Latency: 1 cycle from the Q word to o_vld.
  - o_vld duty is 50%.
- Output tags: o_slot = slot of the pair; o_ant = latched i_ant_pos[4*slot+2:4*slot].
  - o_fram = 1 only with the slot 0, pair 0 output of a frame.
- Marker check, while synced:
  - i_xant at wcnt != L-1 is an error. The block resyncs: the next word becomes wcnt 0 of slot+1, and any held I is discarded.
  - No i_xant at wcnt == L-1 is an error, but counting continues without resync.
- On each error: o_err is set (sticky), and o_err_cnt increments, saturating at all-ones.
- i_fram while synced (mid-dwell or early): immediate realignment to slot 0, wcnt 0. The held I is discarded and no pending pair is emitted. This is not counted as an error.
- i_fram and i_xant in the same cycle: i_fram wins; i_xant is ignored with no error.
- i_clr_err alone: o_err = 0, o_err_cnt = 0 next cycle.
  - If an error occurs in the same cycle, the result is o_err = 1, o_err_cnt = 1.
- Odd L is impossible, so no pair ever spans a dwell boundary.

Test Plan:
- Reset then 20M stream: i_fram, ramp data 0,1,2..., i_xant every 16th word, i_ant_pos=0x76543210 -> o_vld every 2nd cycle, first o_data=0x00000001 with o_fram=1, o_slot=o_ant=0. Slot 1 first o_data=0x00100011. Slot 7 is followed by slot 0; o_err stays 0.
- 5M, i_ant_pos=0x01234567 -> 32 samples per slot; slot 0 reports o_ant=7, slot 3 reports o_ant=4. Changing i_ant_pos mid-frame has no effect until the next i_fram.
- Early i_xant at wcnt 9 in 20M -> o_err=1, o_err_cnt=1. The next word starts the following slot; its first o_data pair comes from words 0/1 of that slot.
- Missing i_xant at wcnt 15 -> o_err_cnt increments, slot still advances normally. 300 consecutive faults -> o_err_cnt saturates at 255. i_clr_err -> 0.
- i_fram mid-dwell at wcnt 7 (held I pending) -> no output for the orphan I, o_err unchanged. Next o_vld carries o_fram=1, o_slot=0.
- Async reset asserted mid-frame -> all outputs 0 immediately. After release, no o_vld until the next i_fram.

Source files
------------

// File: rtl/lte_up_dfe_trans_inf_antdeswitch.sv
// rtl/lte_up_dfe_trans_inf_antdeswitch.sv - uplink antenna-switch deserializer: I/Q word pairing, slot/antenna tagging, marker check
module lte_up_dfe_trans_inf_antdeswitch #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 sys_clk_491p52,
    input  logic                 sys_rst_491p52,
    input  logic [1:0]           i_mod_sel,
    input  logic [31:0]          i_ant_pos,
    input  logic                 i_fram,
    input  logic                 i_xant,
    input  logic [15:0]          i_data,
    input  logic                 i_clr_err,
    output logic                 o_fram,
    output logic                 o_vld,
    output logic [2:0]           o_slot,
    output logic [2:0]           o_ant,
    output logic [31:0]          o_data,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    logic        r_synced;
    logic [1:0]  r_mod_sel;
    logic [31:0] r_ant_pos;
    logic [5:0]  r_wcnt;
    logic [2:0]  r_slot;
    logic [15:0] r_hold_i;
    logic        r_fram_pend;

    logic [5:0]  w_last_idx;
    logic        w_at_last;
    logic        w_early;
    logic        w_miss;
    logic        w_err;
    logic        w_emit;
    logic [2:0]  w_ant;

    always_comb begin
        w_last_idx = 6'd31;
        case (r_mod_sel)
            2'd0:    w_last_idx = 6'd63;
            2'd3:    w_last_idx = 6'd15;
            default: w_last_idx = 6'd31;
        endcase
    end

    assign w_at_last = (r_wcnt == w_last_idx);
    // i_fram overrides the marker entirely, so neither check applies on that word
    assign w_early   = r_synced & ~i_fram & i_xant & ~w_at_last;
    assign w_miss    = r_synced & ~i_fram & ~i_xant & w_at_last;
    assign w_err     = w_early | w_miss;
    // an early marker drops the current word, so a Q arriving with it is not paired
    assign w_emit    = r_synced & ~i_fram & ~w_early & r_wcnt[0];
    assign w_ant     = r_ant_pos[{r_slot, 2'b00} +: 3];

    always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
        if (sys_rst_491p52) begin
            r_synced    <= 1'b0;
            r_mod_sel   <= 2'd0;
            r_ant_pos   <= 32'd0;
            r_wcnt      <= 6'd0;
            r_slot      <= 3'd0;
            r_hold_i    <= 16'd0;
            r_fram_pend <= 1'b0;
            o_fram      <= 1'b0;
            o_vld       <= 1'b0;
            o_slot      <= 3'd0;
            o_ant       <= 3'd0;
            o_data      <= 32'd0;
        end else begin
            o_vld  <= w_emit;
            o_fram <= w_emit & r_fram_pend & (r_slot == 3'd0);
            if (w_emit) begin
                o_data      <= {r_hold_i, i_data};
                o_slot      <= r_slot;
                o_ant       <= w_ant;
                r_fram_pend <= 1'b0;
            end

            if (i_fram) begin
                r_synced    <= 1'b1;
                r_mod_sel   <= i_mod_sel;
                r_ant_pos   <= i_ant_pos;
                r_wcnt      <= 6'd1;
                r_slot      <= 3'd0;
                r_hold_i    <= i_data;
                r_fram_pend <= 1'b1;
            end else if (r_synced) begin
                if (w_early) begin
                    r_wcnt   <= 6'd0;
                    r_slot   <= r_slot + 3'd1;
                    r_hold_i <= 16'd0;
                end else begin
                    if (!r_wcnt[0]) begin
                        r_hold_i <= i_data;
                    end
                    if (w_at_last) begin
                        r_wcnt <= 6'd0;
                        r_slot <= r_slot + 3'd1;
                    end else begin
                        r_wcnt <= r_wcnt + 6'd1;
                    end
                end
            end
        end
    end

    // a clear coinciding with a new error leaves exactly that one error recorded
    always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
        if (sys_rst_491p52) begin
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else if (i_clr_err) begin
            o_err     <= w_err;
            o_err_cnt <= w_err ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_err) begin
            o_err <= 1'b1;
            if (o_err_cnt != {ERR_CNT_W{1'b1}}) begin
                o_err_cnt <= o_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_lte_up_dfe_trans_inf_antdeswitch.sv
// tb/tb_lte_up_dfe_trans_inf_antdeswitch.sv - self-checking bench for the uplink antenna deserializer
module tb_lte_up_dfe_trans_inf_antdeswitch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_mod_sel = 2'd0;
    logic [31:0] i_ant_pos = 32'd0;
    logic        i_fram = 1'b0;
    logic        i_xant = 1'b0;
    logic [15:0] i_data = 16'd0;
    logic        i_clr_err = 1'b0;
    logic        o_fram, o_vld, o_err;
    logic [2:0]  o_slot, o_ant;
    logic [31:0] o_data;
    logic [7:0]  o_err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: position inside the antenna dwell sequence
    bit        m_sync, m_hv, m_fp, m_err;
    int        m_mod, m_wc, m_slot, m_cnt;
    bit [31:0] m_ant;
    bit [15:0] m_held;
    bit        e_vld, e_fram;
    bit [31:0] e_data;
    int        e_slot, e_ant;

    lte_up_dfe_trans_inf_antdeswitch #(.ERR_CNT_W(8)) dut (
        .sys_clk_491p52 (clk),
        .sys_rst_491p52 (rst),
        .i_mod_sel      (i_mod_sel),
        .i_ant_pos      (i_ant_pos),
        .i_fram         (i_fram),
        .i_xant         (i_xant),
        .i_data         (i_data),
        .i_clr_err      (i_clr_err),
        .o_fram         (o_fram),
        .o_vld          (o_vld),
        .o_slot         (o_slot),
        .o_ant          (o_ant),
        .o_data         (o_data),
        .o_err          (o_err),
        .o_err_cnt      (o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dwell_len(input int mod);
        return (mod == 0) ? 64 : ((mod == 3) ? 16 : 32);
    endfunction

    function automatic bit good_x();
        return m_sync && (m_wc == dwell_len(m_mod) - 1);
    endfunction

    task automatic model_reset();
        m_sync = 0; m_hv = 0; m_fp = 0; m_err = 0;
        m_mod = 0; m_wc = 0; m_slot = 0; m_cnt = 0; m_ant = 0; m_held = 0;
        e_vld = 0; e_fram = 0; e_data = 0; e_slot = 0; e_ant = 0;
    endtask

    task automatic model_word(input bit f, input bit x, input bit [15:0] d, input bit clr);
        bit ev;
        int last;
        ev = 0; e_vld = 0; e_fram = 0;
        last = dwell_len(m_mod) - 1;
        if (f) begin
            m_sync = 1; m_mod = i_mod_sel; m_ant = i_ant_pos;
            m_held = d; m_hv = 1; m_wc = 1; m_slot = 0; m_fp = 1;
        end else if (m_sync) begin
            if (x && m_wc != last) begin
                ev = 1; m_hv = 0; m_wc = 0; m_slot = (m_slot + 1) % 8;
            end else begin
                if (!x) ev = (m_wc == last);
                if (m_wc % 2 == 0) begin
                    m_held = d; m_hv = 1;
                end else if (m_hv) begin
                    e_vld = 1; e_data = {m_held, d}; e_slot = m_slot;
                    e_ant = (m_ant >> (4 * m_slot)) & 7;
                    e_fram = m_fp && (m_slot == 0);
                    m_fp = 0; m_hv = 0;
                end
                if (m_wc == last) begin
                    m_wc = 0; m_slot = (m_slot + 1) % 8;
                end else begin
                    m_wc++;
                end
            end
        end
        if (clr) begin
            m_err = ev; m_cnt = ev ? 1 : 0;
        end else if (ev) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic word(input bit f, input bit x, input bit [15:0] d, input bit clr);
        i_fram = f; i_xant = x; i_data = d; i_clr_err = clr;
        model_word(f, x, d, clr);
        @(posedge clk);
        #1;
        chk("vld", o_vld, e_vld);
        chk("fram", o_fram, e_fram);
        chk("err", o_err, m_err);
        chk("err_cnt", o_err_cnt, m_cnt);
        if (e_vld) begin
            chk("data", o_data, e_data);
            chk("slot", o_slot, e_slot);
            chk("ant", o_ant, e_ant);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, o_vld, 0);
        chk({tag, "_fram"}, o_fram, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_slot"}, o_slot, 0);
        chk({tag, "_ant"}, o_ant, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_cnt"}, o_err_cnt, 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // unsynced: markers and data produce nothing
        for (int k = 0; k < 20; k++) word(0, k[0], 16'(k), 0);

        // 20M ramp over one frame plus wrap into slot 0
        i_mod_sel = 2'd3; i_ant_pos = 32'h76543210;
        word(1, 0, 16'd0, 0);
        for (int w = 1; w < 144; w++) begin
            word(0, good_x(), 16'(w), 0);
            if (w == 1) begin
                chk("first_data", o_data, 32'h00000001);
                chk("first_fram", o_fram, 1);
            end
            if (w == 17) chk("slot1_data", o_data, 32'h00100011);
            if (w == 129) chk("wrap_slot0", o_slot, 0);
        end
        chk("20m_no_err", o_err, 0);

        // 5M with a mid-frame antenna map change
        i_mod_sel = 2'd0; i_ant_pos = 32'h01234567;
        word(1, 0, 16'd0, 0);
        for (int w = 1; w < 512; w++) begin
            if (w == 100) begin
                i_ant_pos = 32'hFFFFFFFF; i_mod_sel = 2'd3;
            end
            word(0, good_x(), 16'(w), 0);
            if (w == 1) chk("5m_slot0_ant", o_ant, 7);
            if (w == 193) chk("5m_slot3_ant", o_ant, 4);
        end

        // early marker at wcnt 9 in 20M
        i_mod_sel = 2'd3; i_ant_pos = 32'h76543210;
        word(1, 0, 16'd0, 0);
        for (int w = 1; w < 10; w++) word(0, w == 9, 16'(w), 0);
        chk("early_err", o_err, 1);
        chk("early_cnt", o_err_cnt, 1);
        word(0, good_x(), 16'h0100, 0);
        word(0, good_x(), 16'h0101, 0);
        chk("resync_data", o_data, 32'h01000101);
        chk("resync_slot", o_slot, 1);
        for (int w = 2; w < 16; w++) word(0, good_x(), 16'(w), 0);
        // missing marker: counts but slot advances
        for (int w = 0; w < 18; w++) word(0, (w == 15) ? 1'b0 : good_x(), 16'(w), 0);
        chk("miss_cnt", o_err_cnt, 2);
        chk("miss_slot", o_slot, 3);
        for (int k = 0; k < 300; k++) word(0, 1, 16'(k), 0);
        chk("sat_cnt", o_err_cnt, 255);
        word(0, good_x(), 16'h5555, 1);
        chk("clr_cnt", o_err_cnt, 0);
        chk("clr_err", o_err, 0);
        // clear colliding with an early marker
        word(0, !good_x(), 16'h1234, 1);
        chk("clr_coll_cnt", o_err_cnt, 1);

        // i_fram mid-dwell at wcnt 7 with an I pending
        word(1, 0, 16'd0, 1);
        for (int w = 1; w < 7; w++) word(0, 0, 16'(w), 0);
        word(1, 1, 16'hAAAA, 0);
        chk("realign_no_err", o_err, 0);
        word(0, good_x(), 16'hBBBB, 0);
        chk("realign_fram", o_fram, 1);
        chk("realign_data", o_data, 32'hAAAABBBB);

        // async reset mid-frame
        for (int w = 0; w < 5; w++) word(0, good_x(), 16'(w), 0);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) word(0, k[3], 16'(k), 0);

        // randomized frames with sporadic faults, clears and realignments
        for (int fr = 0; fr < 5; fr++) begin
            i_mod_sel = 2'($urandom_range(0, 3));
            i_ant_pos = $urandom;
            word(1, 0, 16'($urandom), 0);
            for (int w = 0; w < 8 * dwell_len(i_mod_sel); w++) begin
                bit x;
                x = good_x();
                if ($urandom_range(0, 39) == 0) x = !x;
                if ($urandom_range(0, 63) == 0) i_ant_pos = $urandom;
                word($urandom_range(0, 299) == 0, x, 16'($urandom),
                     $urandom_range(0, 49) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
